// File: rtl/branch_fwd_scoreboard.sv
// rtl/branch_fwd_scoreboard.sv - decode-stage branch operand forwarding and hazard scoreboard
// Tracks destination tags of in-flight instructions and picks the youngest producer per branch source.
module branch_fwd_scoreboard #(
  parameter int REG_BITS   = 3,
  parameter int DEPTH      = 2,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 8,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic                     issue_load,
  input  logic [REG_BITS-1:0]      issue_rd,
  input  logic                     kill,
  input  logic                     freeze,
  input  logic                     cnt_clr,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [NSRC*REG_BITS-1:0] src_reg,
  output logic [NSRC*SEL_W-1:0]    forward,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_count
);

  // Entry 0 is ID/EX; entry DEPTH is the last stage before writeback.
  logic                entValid [0:DEPTH];
  logic                entWr    [0:DEPTH];
  logic                entLoad  [0:DEPTH];
  logic [REG_BITS-1:0] entRd    [0:DEPTH];

  logic [NSRC-1:0] srcHit;
  logic [NSRC-1:0] srcStall;
  logic            issueAccept;

  always_comb begin
    forward  = '0;
    srcHit   = '0;
    srcStall = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k <= DEPTH; k++) begin
        if (!srcHit[i] && src_valid[i] && entValid[k] && entWr[k] &&
            entRd[k] == src_reg[i*REG_BITS +: REG_BITS]) begin
          srcHit[i] = 1'b1;
          // Youngest producer wins; a not-yet-ready one stalls instead of forwarding.
          if (k == 0 || (entLoad[k] && k < LOAD_STAGE))
            srcStall[i] = 1'b1;
          else
            forward[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  assign stall       = |srcStall;
  assign issueAccept = issue_valid & ~stall & ~kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= DEPTH; k++) begin
        entValid[k] <= 1'b0;
        entWr[k]    <= 1'b0;
        entLoad[k]  <= 1'b0;
        entRd[k]    <= '0;
      end
    end else if (!freeze) begin
      for (int k = DEPTH; k >= 1; k--) begin
        entValid[k] <= entValid[k-1];
        entWr[k]    <= entWr[k-1];
        entLoad[k]  <= entLoad[k-1];
        entRd[k]    <= entRd[k-1];
      end
      entValid[0] <= issueAccept;
      entWr[0]    <= issue_wr;
      entLoad[0]  <= issue_load;
      entRd[0]    <= issue_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (cnt_clr)
      stall_count <= '0;
    else if (stall && !freeze && stall_count != {CNT_W{1'b1}})
      stall_count <= stall_count + 1'b1;
  end

endmodule
